// File: rtl/rvj1_ifetch.sv
// rvj1_ifetch -- instruction fetch unit for the rvj1 core.
//
// Issues sequential word reads to the 2 KB instruction RAM.
// A small prefetch FIFO absorbs the SRAM's one-cycle read latency.
// A redirect (jmp_i) flushes the FIFO, discards any stale response and
// restarts fetch at the jump target.
//
// Ports:
//   wb_clk_i       clock
//   wb_rst_i       synchronous active-high reset
//   fetch_en_i     allow new IRAM reads (IDLE/RUN control, registered)
//   jmp_i          single-cycle redirect request
//   jmp_addr_i     redirect target byte address (bits [1:0] ignored)
//   ram_en_o       IRAM read request this cycle
//   ram_addr_o     word-aligned byte address of the request
//   ram_rdata_i    IRAM read data, valid the cycle after the request
//   instr_o        instruction word at the FIFO head
//   instr_addr_o   byte address of instr_o
//   instr_valid_o  FIFO head is valid
//   instr_ready_i  decoder accepts the head this cycle
module rvj1_ifetch #(
    parameter logic [31:0] BOOT_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        fetch_en_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_addr_i,
    output logic        ram_en_o,
    output logic [31:0] ram_addr_o,
    input  logic [31:0] ram_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_next;
    logic [31:0]   pc;
    logic [31:0]   req_addr;
    logic          inflight;
    logic          drop;
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [31:0]   mem_addr [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          pop, push, flush;
    logic [CW-1:0] credit;
    logic          jmp_unused;

    assign jmp_unused = ^jmp_addr_i[1:0];

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch_en_i)  state_next = RUN;
            RUN:     if (!fetch_en_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request issue. The credit counts FIFO entries plus the outstanding
    // response, less the entry leaving this cycle, so a full FIFO that is
    // being drained still requests and sustains one word per cycle.
    always_comb begin
        credit     = CW'(count) + CW'(inflight) - CW'(pop);
        ram_en_o   = (state == RUN) && !jmp_i && (credit < CW'(FIFO_DEPTH));
        ram_addr_o = pc;
    end

    assign pop           = instr_valid_o && instr_ready_i;
    assign flush         = jmp_i && (state == RUN);
    // A response landing in a flush cycle belongs to the old stream.
    assign push          = inflight && !drop && !flush;
    assign instr_valid_o = (count != '0);
    assign instr_o       = mem_data[rd_ptr];
    assign instr_addr_o  = mem_addr[rd_ptr];

    // Program counter and response tracking
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pc       <= BOOT_ADDR;
            req_addr <= '0;
            inflight <= 1'b0;
            drop     <= 1'b1;
        end else begin
            inflight <= ram_en_o;
            drop     <= 1'b0;
            if (ram_en_o) req_addr <= pc;
            if (jmp_i)         pc <= {jmp_addr_i[31:2], 2'b00};
            else if (ram_en_o) pc <= pc + 32'd4;
        end
    end

    // Prefetch FIFO
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_addr[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= ram_rdata_i;
                mem_addr[wr_ptr] <= req_addr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i)
            assert (!(push && !pop && !flush && count == (PW + 1)'(FIFO_DEPTH)));
    end
`endif

endmodule
